// File: rtl/escalonador_noite.sv
// rtl/escalonador_noite.sv - night-phase turn scheduler for lobo, vidente and medico
//
// Purpose: once started by the main controller, grants one exclusive turn to
// each living special role (lobo, vidente, medico, in that order), captures
// each role's target, resolves whether a kill happens and pulses fim_noite.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-low reset
//   inicia_noite         one-cycle start pulse (honoured only when idle)
//   papeis_vivos[2:0]    role-alive flags: bit0 lobo, bit1 vidente, bit2 medico
//   jogadores_vivos      player alive mask
//   confirma, alvo       target confirmation pulse and selected target index
//   turno                active turn: 0 none, 1 lobo, 2 vidente, 3 medico
//   alvo_lobo/vidente/medico  registered targets per role
//   acoes_validas        per-role "action captured this night" flags
//   morte_valida, alvo_morte  night outcome, held until the next night
//   erro_alvo            one-cycle pulse after an invalid confirmation
//   fim_noite            one-cycle pulse when the night is resolved
//   db_estado            state encoding for debug (4'hF on illegal encoding)

module escalonador_noite #(
  parameter int N_JOGADORES = 8,
  parameter int ALVO_W      = 3,
  parameter int TIMEOUT     = 1000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inicia_noite,
  input  logic [2:0]             papeis_vivos,
  input  logic [N_JOGADORES-1:0] jogadores_vivos,
  input  logic                   confirma,
  input  logic [ALVO_W-1:0]      alvo,
  output logic [1:0]             turno,
  output logic [ALVO_W-1:0]      alvo_lobo,
  output logic [ALVO_W-1:0]      alvo_vidente,
  output logic [ALVO_W-1:0]      alvo_medico,
  output logic [2:0]             acoes_validas,
  output logic                   morte_valida,
  output logic [ALVO_W-1:0]      alvo_morte,
  output logic                   erro_alvo,
  output logic                   fim_noite,
  output logic [3:0]             db_estado
);

  localparam int VW = 2 ** ALVO_W;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    VEZ_LOBO    = 3'd1,
    VEZ_VIDENTE = 3'd2,
    VEZ_MEDICO  = 3'd3,
    RESOLVE     = 3'd4,
    FIM         = 3'd5
  } estado_t;

  estado_t       estado, prox_estado;
  logic [CW-1:0] contador;
  logic [VW-1:0] vivos_ext;
  logic          em_vez;
  logic          alvo_valido;
  logic          estourou;
  logic          morte_calc;

  // Zero-extending the mask to every encodable index makes out-of-range
  // targets read as dead players, which folds the range check into the lookup.
  assign vivos_ext   = VW'(jogadores_vivos);
  assign alvo_valido = vivos_ext[alvo];
  assign em_vez      = (estado == VEZ_LOBO) || (estado == VEZ_VIDENTE) || (estado == VEZ_MEDICO);
  assign estourou    = (contador == CW'(TIMEOUT - 1));
  assign morte_calc  = acoes_validas[0] && !(acoes_validas[2] && (alvo_medico == alvo_lobo));

  // First alive role strictly after position 'apos' (0 = before lobo).
  function automatic estado_t proximo(input logic [1:0] apos, input logic [2:0] p);
    if (apos < 2'd1 && p[0]) return VEZ_LOBO;
    if (apos < 2'd2 && p[1]) return VEZ_VIDENTE;
    if (apos < 2'd3 && p[2]) return VEZ_MEDICO;
    return RESOLVE;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= prox_estado;
  end

  always_comb begin
    prox_estado = estado;
    turno       = 2'd0;
    db_estado   = {1'b0, estado};
    case (estado)
      OCIOSO: begin
        if (inicia_noite) prox_estado = proximo(2'd0, papeis_vivos);
      end
      VEZ_LOBO, VEZ_VIDENTE, VEZ_MEDICO: begin
        turno = estado[1:0];
        if ((confirma && alvo_valido) || estourou)
          prox_estado = proximo(estado[1:0], papeis_vivos);
      end
      RESOLVE: prox_estado = FIM;
      FIM:     prox_estado = OCIOSO;
      default: begin
        prox_estado = OCIOSO;
        db_estado   = 4'hF;
      end
    endcase
  end

  // Counter restarts on every state change so each turn gets a full budget.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                contador <= '0;
    else if (!em_vez || prox_estado != estado) contador <= '0;
    else                                       contador <= contador + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alvo_lobo     <= '0;
      alvo_vidente  <= '0;
      alvo_medico   <= '0;
      acoes_validas <= '0;
      morte_valida  <= 1'b0;
      alvo_morte    <= '0;
      erro_alvo     <= 1'b0;
      fim_noite     <= 1'b0;
    end else begin
      erro_alvo <= 1'b0;
      fim_noite <= (prox_estado == FIM);
      if (estado == OCIOSO && inicia_noite) begin
        acoes_validas <= '0;
        morte_valida  <= 1'b0;
        alvo_morte    <= '0;
      end
      if (em_vez && confirma) begin
        if (alvo_valido) begin
          case (estado)
            VEZ_LOBO:    begin alvo_lobo    <= alvo; acoes_validas[0] <= 1'b1; end
            VEZ_VIDENTE: begin alvo_vidente <= alvo; acoes_validas[1] <= 1'b1; end
            default:     begin alvo_medico  <= alvo; acoes_validas[2] <= 1'b1; end
          endcase
        end else begin
          erro_alvo <= 1'b1;
        end
      end
      if (estado == RESOLVE) begin
        morte_valida <= morte_calc;
        alvo_morte   <= morte_calc ? alvo_lobo : '0;
      end
    end
  end

endmodule

// File: tb/tb_escalonador_noite.sv
// tb/tb_escalonador_noite.sv - directed self-checking bench for escalonador_noite

module tb_escalonador_noite;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       inicia_noite = 1'b0;
  logic [2:0] papeis_vivos = 3'b111;
  logic [7:0] jogadores_vivos = 8'hFF;
  logic       confirma = 1'b0;
  logic [2:0] alvo = 3'd0;
  logic [1:0] turno;
  logic [2:0] alvo_lobo, alvo_vidente, alvo_medico;
  logic [2:0] acoes_validas;
  logic       morte_valida;
  logic [2:0] alvo_morte;
  logic       erro_alvo, fim_noite;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;

  escalonador_noite #(.N_JOGADORES(8), .ALVO_W(3), .TIMEOUT(10)) dut (
    .clock(clock), .reset(reset), .inicia_noite(inicia_noite),
    .papeis_vivos(papeis_vivos), .jogadores_vivos(jogadores_vivos),
    .confirma(confirma), .alvo(alvo), .turno(turno),
    .alvo_lobo(alvo_lobo), .alvo_vidente(alvo_vidente), .alvo_medico(alvo_medico),
    .acoes_validas(acoes_validas), .morte_valida(morte_valida), .alvo_morte(alvo_morte),
    .erro_alvo(erro_alvo), .fim_noite(fim_noite), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_night();
    inicia_noite = 1'b1;
    tick();
    inicia_noite = 1'b0;
  endtask

  task automatic pulse_confirma(input logic [2:0] a);
    alvo = a;
    confirma = 1'b1;
    tick();
    confirma = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({turno, acoes_validas, morte_valida, erro_alvo, fim_noite} !== 8'd0) begin
      $display("FAIL reset_outputs: got %b required 0", {turno, acoes_validas, morte_valida, erro_alvo, fim_noite});
      errors++;
    end
    checks++;
    if ({alvo_lobo, alvo_vidente, alvo_medico, alvo_morte, db_estado} !== 16'd0) begin
      $display("FAIL reset_targets: got %h required 0", {alvo_lobo, alvo_vidente, alvo_medico, alvo_morte, db_estado});
      errors++;
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_full_night_saved();
    papeis_vivos = 3'b111;
    jogadores_vivos = 8'hFF;
    start_night();
    checks++;
    if (turno !== 2'd1) begin $display("FAIL t1_turno_lobo: got %0d required 1", turno); errors++; end
    pulse_confirma(3'd3);
    checks++;
    if (turno !== 2'd2) begin $display("FAIL t1_turno_vidente: got %0d required 2", turno); errors++; end
    pulse_confirma(3'd5);
    checks++;
    if (turno !== 2'd3) begin $display("FAIL t1_turno_medico: got %0d required 3", turno); errors++; end
    pulse_confirma(3'd3);
    checks++;
    if (fim_noite !== 1'b0 || db_estado !== 4'd4) begin
      $display("FAIL t1_resolve: got fim=%b estado=%0d required fim=0 estado=4", fim_noite, db_estado); errors++;
    end
    tick();
    checks++;
    if (fim_noite !== 1'b1) begin $display("FAIL t1_fim_pulse: got %b required 1", fim_noite); errors++; end
    checks++;
    if ({alvo_lobo, alvo_vidente, alvo_medico} !== {3'd3, 3'd5, 3'd3}) begin
      $display("FAIL t1_targets: got %0d %0d %0d required 3 5 3", alvo_lobo, alvo_vidente, alvo_medico); errors++;
    end
    checks++;
    if (acoes_validas !== 3'b111 || morte_valida !== 1'b0) begin
      $display("FAIL t1_outcome: got acoes=%b morte=%b required acoes=111 morte=0", acoes_validas, morte_valida); errors++;
    end
    tick();
    checks++;
    if (fim_noite !== 1'b0 || db_estado !== 4'd0) begin
      $display("FAIL t1_fim_once: got fim=%b estado=%0d required fim=0 estado=0", fim_noite, db_estado); errors++;
    end
  endtask

  task automatic test_kill();
    start_night();
    pulse_confirma(3'd3);
    pulse_confirma(3'd5);
    pulse_confirma(3'd6);
    tick();
    tick();
    checks++;
    if (morte_valida !== 1'b1 || alvo_morte !== 3'd3) begin
      $display("FAIL t2_kill: got morte=%b alvo=%0d required morte=1 alvo=3", morte_valida, alvo_morte); errors++;
    end
    // confirma while idle is ignored and the outcome holds
    pulse_confirma(3'd1);
    checks++;
    if (turno !== 2'd0 || alvo_medico !== 3'd6 || morte_valida !== 1'b1) begin
      $display("FAIL t2_hold: got turno=%0d medico=%0d morte=%b required 0 6 1", turno, alvo_medico, morte_valida); errors++;
    end
  endtask

  task automatic test_skip_vidente();
    papeis_vivos = 3'b101;
    start_night();
    checks++;
    if (turno !== 2'd1 || acoes_validas !== 3'b000 || morte_valida !== 1'b0) begin
      $display("FAIL t3_clear: got turno=%0d acoes=%b morte=%b required 1 000 0", turno, acoes_validas, morte_valida); errors++;
    end
    pulse_confirma(3'd2);
    checks++;
    if (turno !== 2'd3) begin $display("FAIL t3_skip: got %0d required 3", turno); errors++; end
    pulse_confirma(3'd2);
    tick();
    checks++;
    if (acoes_validas !== 3'b101 || morte_valida !== 1'b0 || fim_noite !== 1'b1) begin
      $display("FAIL t3_outcome: got acoes=%b morte=%b fim=%b required 101 0 1", acoes_validas, morte_valida, fim_noite); errors++;
    end
    tick();
  endtask

  task automatic test_invalid_target();
    papeis_vivos = 3'b111;
    jogadores_vivos = 8'hF7;
    start_night();
    pulse_confirma(3'd3);
    checks++;
    if (erro_alvo !== 1'b1 || turno !== 2'd1) begin
      $display("FAIL t4_erro: got erro=%b turno=%0d required 1 1", erro_alvo, turno); errors++;
    end
    tick();
    checks++;
    if (erro_alvo !== 1'b0) begin $display("FAIL t4_erro_once: got %b required 0", erro_alvo); errors++; end
    pulse_confirma(3'd4);
    checks++;
    if (turno !== 2'd2 || alvo_lobo !== 3'd4 || erro_alvo !== 1'b0) begin
      $display("FAIL t4_advance: got turno=%0d lobo=%0d erro=%b required 2 4 0", turno, alvo_lobo, erro_alvo); errors++;
    end
    pulse_confirma(3'd1);
    pulse_confirma(3'd1);
    tick();
    checks++;
    if (morte_valida !== 1'b1 || alvo_morte !== 3'd4) begin
      $display("FAIL t4_kill: got morte=%b alvo=%0d required 1 4", morte_valida, alvo_morte); errors++;
    end
    tick();
  endtask

  task automatic test_timeout();
    int len;
    papeis_vivos = 3'b111;
    jogadores_vivos = 8'hFF;
    start_night();
    for (int r = 1; r <= 3; r++) begin
      len = 0;
      while (turno == 2'(r) && len < 20) begin
        len++;
        tick();
      end
      checks++;
      if (len !== 10) begin $display("FAIL t5_turn_len_%0d: got %0d required 10", r, len); errors++; end
    end
    tick();
    checks++;
    if (fim_noite !== 1'b1 || acoes_validas !== 3'b000 || morte_valida !== 1'b0) begin
      $display("FAIL t5_outcome: got fim=%b acoes=%b morte=%b required 1 000 0", fim_noite, acoes_validas, morte_valida); errors++;
    end
    checks++;
    if (alvo_lobo !== 3'd4) begin $display("FAIL t5_lobo_kept: got %0d required 4", alvo_lobo); errors++; end
    tick();
  endtask

  task automatic test_confirma_on_timeout();
    papeis_vivos = 3'b001;
    start_night();
    repeat (9) tick();
    pulse_confirma(3'd7);
    tick();
    checks++;
    if (acoes_validas !== 3'b001 || alvo_lobo !== 3'd7 || morte_valida !== 1'b1) begin
      $display("FAIL t7_confirma_wins: got acoes=%b lobo=%0d morte=%b required 001 7 1", acoes_validas, alvo_lobo, morte_valida); errors++;
    end
    tick();
  endtask

  task automatic test_no_roles();
    papeis_vivos = 3'b000;
    start_night();
    checks++;
    if (db_estado !== 4'd4 || turno !== 2'd0) begin
      $display("FAIL t8_direct_resolve: got estado=%0d turno=%0d required 4 0", db_estado, turno); errors++;
    end
    tick();
    checks++;
    if (fim_noite !== 1'b1 || morte_valida !== 1'b0) begin
      $display("FAIL t8_fim: got fim=%b morte=%b required 1 0", fim_noite, morte_valida); errors++;
    end
    tick();
  endtask

  task automatic test_reset_mid_turn();
    papeis_vivos = 3'b111;
    start_night();
    pulse_confirma(3'd2);
    checks++;
    if (turno !== 2'd2) begin $display("FAIL t6_in_vidente: got %0d required 2", turno); errors++; end
    reset = 1'b0;
    #1;
    checks++;
    if ({turno, db_estado, alvo_lobo, acoes_validas, fim_noite} !== 13'd0) begin
      $display("FAIL t6_async_clear: got %b required 0", {turno, db_estado, alvo_lobo, acoes_validas, fim_noite}); errors++;
    end
    tick();
    checks++;
    if ({turno, db_estado, fim_noite, morte_valida, erro_alvo} !== 9'd0) begin
      $display("FAIL t6_held: got %b required 0", {turno, db_estado, fim_noite, morte_valida, erro_alvo}); errors++;
    end
    reset = 1'b1;
    tick();
    start_night();
    checks++;
    if (turno !== 2'd1 || db_estado !== 4'd1) begin
      $display("FAIL t6_fresh_night: got turno=%0d estado=%0d required 1 1", turno, db_estado); errors++;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_full_night_saved();
    test_kill();
    test_skip_vidente();
    test_invalid_target();
    test_timeout();
    test_confirma_on_timeout();
    test_no_roles();
    test_reset_mid_turn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/escalonador_noite.md
Name: escalonador_noite

Overview:
- Sequences the night phase of the game once the main game controller reaches its night-preparation state.
- Grants one exclusive turn to each living special role, in this fixed order: lobo (werewolf), vidente (seer), medico (doctor).
- Captures each role's target and resolves the night outcome.
- Raises a one-cycle completion pulse so the main controller can advance to the day phase.

Parameters:
N_JOGADORES, 8, number of player slots.
ALVO_W, 3, width of a player index; must satisfy 2**ALVO_W >= N_JOGADORES.
TIMEOUT, 1000, maximum number of cycles a turn waits for confirma; must be >= 2.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
inicia_noite  in  1  one-cycle start pulse from the main controller.
papeis_vivos  in  3  role-alive flags: bit0 lobo, bit1 vidente, bit2 medico.
jogadores_vivos  in  N_JOGADORES  alive mask; bit i set means player i is alive.
confirma  in  1  one-cycle pulse (debounced passa) confirming the selected target.
alvo  in  ALVO_W  target index currently selected on the switches.
turno  out  2  active turn: 0 none, 1 lobo, 2 vidente, 3 medico.
alvo_lobo  out  ALVO_W  registered target of the lobo.
alvo_vidente  out  ALVO_W  registered target of the vidente.
alvo_medico  out  ALVO_W  registered target of the medico.
acoes_validas  out  3  per-role "action captured this night" flags; same bit order as papeis_vivos.
morte_valida  out  1  a kill results from this night; held until the next inicia_noite.
alvo_morte  out  ALVO_W  player killed; meaningful only when morte_valida=1.
erro_alvo  out  1  one-cycle pulse when confirma selects an invalid target.
fim_noite  out  1  one-cycle pulse when the night is resolved.
db_estado  out  4  state encoding, for debug display.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to OCIOSO.
  - All outputs are 0; the timeout counter is 0.
- States and encodings: OCIOSO=0, VEZ_LOBO=1, VEZ_VIDENTE=2, VEZ_MEDICO=3, RESOLVE=4, FIM=5. Any other encoding returns to OCIOSO; db_estado=4'hF while in an illegal encoding.
- OCIOSO:
  - turno=0.
  - On inicia_noite: clear acoes_validas, morte_valida and alvo_morte, and enter the first role turn whose papeis_vivos bit is 1.
  - If no role is alive, go directly to RESOLVE.
- VEZ_x (turno = 1, 2 or 3 respectively):
  - The timeout counter is cleared on entry and increments every cycle while in the state.
  - confirma with a valid target: alvo < N_JOGADORES and jogadores_vivos[alvo]=1.
    - Register alvo_x <= alvo and set acoes_validas bit x.
    - Advance to the next alive role in order, or to RESOLVE if none remains.
    - The advance happens on the same clock edge, so turno changes 1 cycle after confirma.
  - confirma with an invalid target: erro_alvo=1 for the next cycle only; stay in VEZ_x; the counter is not reset.
  - Lobo restriction: a lobo targeting itself is allowed; target legality is checked only against jogadores_vivos.
  - Timeout: when the counter reaches TIMEOUT-1 without a valid confirma, advance as above with no capture (bit x stays 0, alvo_x unchanged).
  - confirma on the timeout cycle: the confirma wins.
  - confirma while in OCIOSO, RESOLVE or FIM is ignored.
- RESOLVE (1 cycle):
  - morte_valida = acoes_validas[0] AND NOT (acoes_validas[2] AND alvo_medico == alvo_lobo).
  - alvo_morte = alvo_lobo when morte_valida=1, otherwise 0.
  - Next state: FIM.
- FIM (1 cycle):
  - fim_noite=1.
  - Next state: OCIOSO.
- inicia_noite outside OCIOSO is ignored.
- Register hold: alvo_* and acoes_validas hold their values until the next inicia_noite.
- papeis_vivos is sampled only at the decision points (OCIOSO exit and each turn advance).
- All outputs are registered (Moore style), except turno and db_estado, which decode the current state.
- Reset asserted mid-turn: immediate return to OCIOSO with outputs cleared; no fim_noite is emitted.

Test Plan:
1. All roles alive, jogadores_vivos=8'hFF; inicia_noite; then confirma with alvo=3, alvo=5, alvo=3 -> turno steps 1,2,3; alvo_lobo=3, alvo_vidente=5, alvo_medico=3; acoes_validas=3'b111; morte_valida=0; fim_noite pulses exactly once, 2 cycles after the third confirma.
2. Same sequence but the medico confirms alvo=6 -> morte_valida=1, alvo_morte=3.
3. papeis_vivos=3'b101; inicia_noite -> vidente turn skipped (turno goes 1 to 3); acoes_validas[1]=0.
4. jogadores_vivos=8'hF7; lobo confirms alvo=3 -> erro_alvo pulses 1 cycle, turno stays 1; then confirms alvo=4 -> alvo_lobo=4 and the turn advances.
5. TIMEOUT=10, no confirma -> each turn lasts exactly 10 cycles; acoes_validas=0; morte_valida=0; fim_noite asserted.
6. reset driven low during VEZ_VIDENTE -> next cycle turno=0, all outputs 0, db_estado=0; inicia_noite after reset is released starts a fresh night.
